// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: frame-synchronous scheduler for the single vga_adapter
// pixel port. On each frame tick the clients are visited in index order and
// each gets one pixel burst. Accepted pixels are clipped and registered onto
// plot/x/y/colour with one cycle of latency.
// Optional feature macro: DRAW_ARB_TIMEOUT_EN (stalled-burst abort + sticky
// timeout flag).

// Per-lane clip check: a pixel is visible only inside the XMAX x YMAX window.
module vga_draw_arbiter_lane #(
    parameter int XW   = 8,
    parameter int YW   = 7,
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic [XW-1:0] x_i,
    input  logic [YW-1:0] y_i,
    output logic          vis_o
);
    assign vis_o = (int'(x_i) < XMAX) && (int'(y_i) < YMAX);
endmodule

module vga_draw_arbiter #(
    parameter int NCLI    = 4,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int CW      = 3,
    parameter int XMAX    = 160,
    parameter int YMAX    = 120,
    parameter int TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               frame_tick,
    input  logic [NCLI-1:0]    req,
    input  logic [NCLI-1:0]    last,
    input  logic [NCLI*XW-1:0] x_in,
    input  logic [NCLI*YW-1:0] y_in,
    input  logic [NCLI*CW-1:0] col_in,
    output logic [NCLI-1:0]    gnt,
    output logic               plot,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic [CW-1:0]      colour,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
`ifdef DRAW_ARB_TIMEOUT_EN
    ,
    output logic               timeout
`endif
);
    localparam int IW = (NCLI > 1) ? $clog2(NCLI) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NCLI - 1);

    typedef enum logic [1:0] {IDLE, SCAN, BURST, DONE} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic             plot_q, plot_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [CW-1:0]    col_q, col_d;

    // Unpacked lane views of the flat client buses.
    logic [NCLI-1:0][XW-1:0] lane_x;
    logic [NCLI-1:0][YW-1:0] lane_y;
    logic [NCLI-1:0][CW-1:0] lane_c;
    logic [NCLI-1:0]         lane_vis;

    for (genvar g = 0; g < NCLI; g++) begin : g_lane
        assign lane_x[g] = x_in[g*XW +: XW];
        assign lane_y[g] = y_in[g*YW +: YW];
        assign lane_c[g] = col_in[g*CW +: CW];
        vga_draw_arbiter_lane #(
            .XW(XW), .YW(YW), .XMAX(XMAX), .YMAX(YMAX)
        ) u_lane (
            .x_i   (lane_x[g]),
            .y_i   (lane_y[g]),
            .vis_o (lane_vis[g])
        );
    end

    logic accept;   // handshake completes this cycle
    logic abort;    // stalled burst given up (timeout build only)
    assign accept = (state_q == BURST) && req[idx_q];

`ifdef DRAW_ARB_TIMEOUT_EN
    logic [9:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_q, tmo_d;

    // The abort fires on the stalled cycle that would bring the count to TIMEOUT.
    assign abort = (state_q == BURST) && !req[idx_q] && (tmo_cnt_q == 10'(TIMEOUT - 1));

    // Stall counter: cleared by any accept or when leaving BURST.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_d     = tmo_q | abort;
        if (state_q != BURST || accept || abort) tmo_cnt_d = '0;
        else                                     tmo_cnt_d = tmo_cnt_q + 10'd1;
    end

    // Timeout counter and sticky flag registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign timeout = tmo_q;
`else
    assign abort = 1'b0;
`endif

    // Schedule FSM next state: visit clients in index order, one burst each.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end
            end
            SCAN: begin
                if (req[idx_q])              state_d = BURST;
                else if (idx_q == LAST_IDX)  state_d = DONE;
                else                         idx_d   = idx_q + 1'b1;
            end
            BURST: begin
                if ((accept && last[idx_q]) || abort) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        state_d = SCAN;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // A tick landing on the done cycle starts the next frame directly.
                if (frame_tick) begin
                    state_d = SCAN;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pixel path: clipped pixels complete the handshake but never strobe plot.
    always_comb begin
        overrun_d = overrun_q | (frame_tick && (state_q == SCAN || state_q == BURST));
        plot_d    = accept && lane_vis[idx_q];
        x_d       = x_q;
        y_d       = y_q;
        col_d     = col_q;
        if (plot_d) begin
            x_d   = lane_x[idx_q];
            y_d   = lane_y[idx_q];
            col_d = lane_c[idx_q];
        end
    end

    // State and output registers; reset wins over a coincident frame tick.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            plot_q    <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            col_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_q     <= col_d;
        end
    end

    // One-hot grant to the owning client while a burst is open.
    always_comb begin
        gnt = '0;
        if (state_q == BURST) gnt[idx_q] = 1'b1;
    end

    assign plot       = plot_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = col_q;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: directed and randomized frames against a queue-based
// reference model (per-client pixel lists, expected plot stream, frame length).
module tb_vga_draw_arbiter;
    localparam int NCLI = 4, XW = 8, YW = 7, CW = 3;
`ifdef DRAW_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 1023;
`endif

    typedef logic [XW+YW+CW-1:0] pix_t;

    logic               clock = 1'b0, resetn = 1'b0, frame_tick = 1'b0;
    logic [NCLI-1:0]    req = '0, last = '0;
    logic [NCLI*XW-1:0] x_in = '0;
    logic [NCLI*YW-1:0] y_in = '0;
    logic [NCLI*CW-1:0] col_in = '0;
    logic [NCLI-1:0]    gnt;
    logic               plot, busy, frame_done, overrun;
    logic [XW-1:0]      x;
    logic [YW-1:0]      y;
    logic [CW-1:0]      colour;
`ifdef DRAW_ARB_TIMEOUT_EN
    logic               timeout;
`endif

    vga_draw_arbiter #(.TIMEOUT(TMO)) dut (
        .clock(clock), .resetn(resetn), .frame_tick(frame_tick),
        .req(req), .last(last), .x_in(x_in), .y_in(y_in), .col_in(col_in),
        .gnt(gnt), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .frame_done(frame_done), .overrun(overrun)
`ifdef DRAW_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clock = ~clock;

    int passed = 0, total = 0;

    // Reference model state.
    pix_t lane_q[NCLI][$];     // pixels each client still has to deliver
    int   stall_q[NCLI][$];    // req-low cycles planned before each pixel
    bit   started[NCLI];       // client is mid-burst
    pix_t exp_q[$];            // expected plot stream for the frame
    int   exp_E = 0;           // edge (after tick) at which DONE is expected
    int   edge_cnt = 1000;
    bit   active = 0, ovr_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_px(input int lane, input int px, input int py, input int pc, input int st);
        lane_q[lane].push_back({XW'(px), YW'(py), CW'(pc)});
        stall_q[lane].push_back(st);
    endtask

    // Expected stream: index order, clipped pixels dropped. Frame length is one
    // SCAN cycle per client plus one BURST cycle per pixel and per stall.
    task automatic build_exp();
        pix_t p;
        exp_q.delete();
        exp_E = NCLI;
        for (int i = 0; i < NCLI; i++)
            for (int j = 0; j < lane_q[i].size(); j++) begin
                p = lane_q[i][j];
                exp_E += 1 + stall_q[i][j];
                if (p[XW+YW+CW-1 -: XW] < 160 && p[YW+CW-1 -: YW] < 120) exp_q.push_back(p);
            end
    endtask

    task automatic drive();
        pix_t p;
        for (int i = 0; i < NCLI; i++) begin
            if (lane_q[i].size() > 0) begin
                p = lane_q[i][0];
                req[i]  = (stall_q[i][0] == 0);
                last[i] = (lane_q[i].size() == 1);
                x_in[i*XW +: XW]   = p[XW+YW+CW-1 -: XW];
                y_in[i*YW +: YW]   = p[YW+CW-1 -: YW];
                col_in[i*CW +: CW] = p[CW-1:0];
            end else begin
                req[i]  = 1'b0;
                last[i] = 1'b0;
            end
        end
    endtask

    task automatic cyc(input bit tick, input bit start);
        logic [NCLI-1:0] acc, eg;
        frame_tick = tick;
        acc = gnt & req;
        if (tick && !start && active && edge_cnt < exp_E) ovr_exp = 1;
        @(posedge clock);
        #1;
        frame_tick = 1'b0;
        if (start) begin
            edge_cnt = 0;
            active   = 1;
        end else begin
            edge_cnt++;
        end
        if (plot) begin
            if (exp_q.size() == 0) chk("plot_extra", plot, 0);
            else begin
                chk("plot_pix", {x, y, colour}, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
        chk("busy", busy, active && edge_cnt <= exp_E);
        chk("frame_done", frame_done, active && edge_cnt == exp_E);
        chk("overrun", overrun, ovr_exp);
        chk("gnt_onehot0", $onehot0(gnt), 1);
        for (int i = 0; i < NCLI; i++) begin
            if (acc[i] && lane_q[i].size() > 0) begin
                started[i] = (lane_q[i].size() > 1);
                void'(lane_q[i].pop_front());
                void'(stall_q[i].pop_front());
            end else if (started[i] && stall_q[i].size() > 0 && stall_q[i][0] > 0) begin
                stall_q[i][0]--;
            end
        end
        for (int i = 0; i < NCLI; i++)
            if (started[i]) begin
                eg = '0;
                eg[i] = 1'b1;
                chk("gnt_hold", gnt, eg);
            end
        if (active && edge_cnt == exp_E) begin
            chk("exp_left", exp_q.size(), 0);
            for (int i = 0; i < NCLI; i++) chk("lane_left", lane_q[i].size(), 0);
        end
        drive();
    endtask

    task automatic run_frame(input int ovr_at);
        build_exp();
        cyc(1'b1, 1'b1);
        while (edge_cnt < exp_E) cyc(edge_cnt == ovr_at, 1'b0);
    endtask

    task automatic rand_frame();
        int n;
        for (int i = 0; i < NCLI; i++) begin
            n = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
            for (int j = 0; j < n; j++)
                add_px(i, $urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7),
                       (j == 0 || $urandom_range(0, 3) != 0) ? 0 : $urandom_range(1, 3));
        end
    endtask

    initial begin
        // T1: reset with every client requesting and a tick; reset wins.
        resetn = 1'b0; req = '1; frame_tick = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_xyc", {x, y, colour}, 0);
        frame_tick = 1'b0; resetn = 1'b1;
        drive();
        cyc(1'b0, 1'b0);

        // T2: four 2-pixel bursts, lane colour = lane index.
        for (int i = 0; i < NCLI; i++)
            for (int j = 0; j < 2; j++) add_px(i, 10*i + j, i + j, i, 0);
        run_frame(-1);
        cyc(1'b0, 1'b0);

        // T3: clients 1 and 3 idle; client 2 stalls 3 cycles mid-burst.
        add_px(0, 3, 4, 5, 0);
        add_px(2, 20, 30, 6, 0);
        add_px(2, 21, 31, 7, 3);
        add_px(2, 22, 32, 1, 0);
        run_frame(-1);
        cyc(1'b0, 1'b0);

        // T4: clip boundaries.
        add_px(0, 159, 119, 2, 0);
        add_px(0, 160, 5, 3, 0);
        add_px(0, 7, 120, 4, 0);
        run_frame(-1);
        cyc(1'b0, 1'b0);

        // Randomized frames, half of them chained by a tick on the DONE cycle.
        for (int f = 0; f < 30; f++) begin
            rand_frame();
            run_frame(-1);
            if ($urandom_range(0, 1) != 0) cyc(1'b0, 1'b0);
        end
        cyc(1'b0, 1'b0);

        // T5: tick during client 1's burst sets sticky overrun.
        add_px(0, 1, 1, 1, 0);
        add_px(0, 2, 2, 2, 0);
        for (int j = 0; j < 4; j++) add_px(1, 40 + j, 50, 3, (j == 2) ? 2 : 0);
        add_px(3, 60, 70, 4, 0);
        run_frame(5);
        repeat (3) cyc(1'b0, 1'b0);

        // Reset in the middle of a burst.
        for (int j = 0; j < 4; j++) add_px(0, 5 + j, 6, 1, 0);
        add_px(2, 9, 9, 2, 0);
        build_exp();
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        resetn = 1'b0;
        @(posedge clock);
        #1;
        chk("mrst_gnt", gnt, 0);
        chk("mrst_plot", plot, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_overrun", overrun, 0);
        for (int i = 0; i < NCLI; i++) begin
            lane_q[i].delete();
            stall_q[i].delete();
            started[i] = 0;
        end
        exp_q.delete();
        active = 0; ovr_exp = 0; edge_cnt = 1000;
        resetn = 1'b1;
        drive();
        cyc(1'b0, 1'b0);
        rand_frame();
        run_frame(-1);
        cyc(1'b0, 1'b0);

`ifdef DRAW_ARB_TIMEOUT_EN
        // T6: client 0 granted then goes quiet; the burst is abandoned.
        req = 4'b0011; last = 4'b0010;
        x_in = '0; y_in = '0; col_in = '0;
        x_in[XW +: XW] = 8'd1; y_in[YW +: YW] = 7'd1; col_in[CW +: CW] = 3'd5;
        frame_tick = 1'b1;
        @(posedge clock); #1;
        frame_tick = 1'b0;
        @(posedge clock); #1;
        chk("t6_gnt0", gnt, 4'b0001);
        req = 4'b0010;
        repeat (8) begin
            @(posedge clock); #1;
            chk("t6_noplot", plot, 0);
        end
        chk("t6_scan", gnt, 0);
        @(posedge clock); #1;
        chk("t6_gnt1", gnt, 4'b0010);
        chk("t6_timeout", timeout, 1);
        @(posedge clock); #1;
        chk("t6_plot1", {plot, colour}, {1'b1, 3'd5});
        req = '0;
        repeat (4) @(posedge clock);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
